// File: rtl/arith_wb_pkg.sv
// Shared opcode constants, FSM state type and widths for the arithmetic writeback sequencer.
package arith_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_e;

    // Opcodes 100-111 are NOPs; everything with a clear MSB writes back.
    function automatic logic isArithOp(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/arith_wb_if.sv
// Handshake, register-file write port and status signals of the writeback sequencer.
interface arith_wb_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_opcode;
    logic [2*DATA_W-1:0]     in_result;
    logic [REG_ADDR_W-1:0]   in_rd;
    logic                    rf_we;
    logic [REG_ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;
    logic                    zero_flag;
    logic                    busy;

    modport master (
        output in_valid, in_opcode, in_result, in_rd,
        input  in_ready, rf_we, rf_waddr, rf_wdata, zero_flag, busy
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_rd,
        output in_ready, rf_we, rf_waddr, rf_wdata, zero_flag, busy
    );
endinterface

// File: rtl/arith_wb.sv
// Writeback sequencer: one RF write for ADD/SUB/DIV, low-then-high writes for MUL.
// Optional write counter output wb_count enabled by ARITH_WB_PERF_EN.
module arith_wb
    import arith_pkg::*;
#(
    parameter int DATA_W     = arith_pkg::DATA_W,
    parameter int REG_ADDR_W = arith_pkg::REG_ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    arith_wb_if.slave  bus
`ifdef ARITH_WB_PERF_EN
    ,
    output logic [15:0] wb_count
`endif
);

    wb_state_e               state_q, state_d;
    logic [2:0]              opcode_q, opcode_d;
    logic [2*DATA_W-1:0]     result_q, result_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    zero_q;
    logic                    inReady_q;
    logic                    busy_q;
    logic                    rfWe_q;
    logic [REG_ADDR_W-1:0]   rfWaddr_q;
    logic [DATA_W-1:0]       rfWdata_q;
    logic                    xfer;
    logic                    startOp;

    assign xfer    = bus.in_valid && inReady_q;
    assign startOp = xfer && isArithOp(bus.in_opcode);

    // Next state and capture; capture happens on every transfer, NOPs included.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (xfer) begin
            opcode_d = bus.in_opcode;
            result_d = bus.in_result;
            rd_d     = bus.in_rd;
        end
        case (state_q)
            IDLE:    state_d = startOp ? WR_LO : IDLE;
            WR_LO: begin
                if (opcode_q == OP_MUL) state_d = WR_HI;
                else                    state_d = startOp ? WR_LO : IDLE;
            end
            WR_HI:   state_d = startOp ? WR_LO : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so the RF port sees no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            zero_q    <= 1'b0;
            inReady_q <= 1'b1;
            busy_q    <= 1'b0;
            rfWe_q    <= 1'b0;
            rfWaddr_q <= '0;
            rfWdata_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            if (state_q == WR_LO) zero_q <= (result_q == '0);
            inReady_q <= !((state_d == WR_LO) && (opcode_d == OP_MUL));
            busy_q    <= (state_d != IDLE);
            rfWe_q    <= (state_d != IDLE);
            case (state_d)
                WR_LO: begin
                    rfWaddr_q <= rd_d;
                    rfWdata_q <= result_d[DATA_W-1:0];
                end
                WR_HI: begin
                    rfWaddr_q <= rd_d + 1'b1;
                    rfWdata_q <= result_d[2*DATA_W-1:DATA_W];
                end
                default: begin
                    rfWaddr_q <= '0;
                    rfWdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.busy      = busy_q;
    assign bus.rf_we     = rfWe_q;
    assign bus.rf_waddr  = rfWaddr_q;
    assign bus.rf_wdata  = rfWdata_q;
    assign bus.zero_flag = zero_q;

`ifdef ARITH_WB_PERF_EN
    logic [15:0] wbCount_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                wbCount_q <= '0;
        else if (rfWe_q && wbCount_q != 16'hFFFF) wbCount_q <= wbCount_q + 16'd1;
    end

    assign wb_count = wbCount_q;
`endif

endmodule

// File: doc/arith_wb.md
Name: arith_wb

Overview:
- Writeback sequencer directly downstream of the arithmetic unit.
- Accepts one 32-bit arithmetic result per handshake, together with its opcode and destination register index.
- Writes the result into the 16-bit register file through a single write port: one write for ADD/SUB/DIV, two consecutive writes (low word, then high word) for MUL.
- Maintains a registered zero flag for the branch logic.

Parameters:
- DATA_W, 16, register-file word width; result width is 2*DATA_W.
- REG_ADDR_W, 3, register index width (8 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  result/opcode/rd are valid this cycle.
- in_ready  output  1  block can accept a result this cycle.
- in_opcode  input  3  opcode that produced the result.
- in_result  input  2*DATA_W  arithmetic result.
- in_rd  input  REG_ADDR_W  destination register index.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  REG_ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- zero_flag  output  1  last completed valid op produced an all-zero 32-bit result.
- busy  output  1  a write sequence is in progress (state != IDLE).

Behaviour:
- Opcodes: 000 ADD, 001 MUL, 010 SUB (absolute difference), 011 DIV; 100-111 are NOP.
- Handshake:
  - Transfer occurs on a rising edge with in_valid && in_ready.
  - in_opcode, in_result and in_rd are captured into internal registers at that edge.
  - Inputs are don't-care when in_valid=0.
- FSM states:
  - IDLE:
    - in_ready=1, rf_we=0.
    - Transfer of ADD/SUB/DIV/MUL -> WR_LO.
    - Transfer of a NOP -> stays IDLE; no write, flag unchanged.
  - WR_LO:
    - rf_we=1, rf_waddr=rd, rf_wdata=result[15:0].
    - zero_flag <= (result==0) at the end of this cycle.
    - MUL -> WR_HI.
    - Otherwise -> WR_LO again if a new valid op is transferred this cycle, IDLE if a NOP or no transfer.
    - in_ready = !MUL in this state.
  - WR_HI:
    - rf_we=1, rf_waddr=rd+1 modulo 2^REG_ADDR_W (rd=7 wraps to 0), rf_wdata=result[31:16].
    - in_ready=1.
    - Transfer of a valid op -> WR_LO; else -> IDLE.
- Latency: the first register write occurs in the cycle after the transfer.
- Throughput, with back-to-back transfers accepted in the final write state:
  - ADD/SUB/DIV: 1 result per cycle.
  - MUL: 1 per 2 cycles.
- A new transfer overwrites the captured registers at the same edge that ends the current final write. The in-flight write data is unaffected because it is driven from the previous register contents during that cycle.
- All write-port outputs are driven from registered state; no combinational path from the in_* data ports to the rf_* ports.
- in_ready depends only on state and the captured opcode, never on in_valid.
- Reset (asynchronous, any time, including mid-sequence):
  - State goes to IDLE; captured registers cleared to 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, zero_flag=0, busy=0, in_ready=1 after reset deasserts.
  - A pending MUL high-word write is abandoned.

Optional Feature:
- Macro: ARITH_WB_PERF_EN.
- Defined:
  - Adds output wb_count [15:0], reset 0.
  - Increments by 1 on every cycle with rf_we=1 and saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package arith_pkg:
  - Opcode constants OP_ADD=3'b000, OP_MUL=3'b001, OP_SUB=3'b010, OP_DIV=3'b011.
  - FSM state typedef (IDLE, WR_LO, WR_HI).
  - DATA_W default.
- No sub-module; a single FSM plus capture registers. The register file stays external.

Test Plan:
- Reset: assert rst mid-WR_HI of a MUL -> rf_we=0, zero_flag=0 immediately; after release in_ready=1, and no high-word write occurs.
- ADD: opcode 000, result 32'h0000_1234, rd=3 -> next cycle rf_we=1, waddr=3, wdata=16'h1234; zero_flag=0; single write.
- MUL: opcode 001, result 32'h0001_E240, rd=7 -> cycle 1 writes 16'hE240 to R7; cycle 2 writes 16'h0001 to R0; in_ready=0 during cycle 1.
- Back-to-back: 4 consecutive SUB ops with in_valid held high, rd=1..4 -> writes on 4 consecutive cycles, in_ready never drops.
- Zero/NOP: DIV result 0 -> zero_flag=1; then opcode 101 with result 32'hFFFF_FFFF -> no write, zero_flag stays 1.
- With ARITH_WB_PERF_EN defined: 1 MUL + 2 ADD -> wb_count=4.
